// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: serves active-low SRAM strobe bursts from an
// on-chip word array, with one address mapped to switches (read) / hex (write).
module lc3_mem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_CE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_to_SRAM,
    input  logic [15:0] Switches,
    output logic [15:0] Data_from_SRAM,
    output logic [15:0] Hex_Out,
    output logic        Conflict
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, RD, WR1, WR2} state_t;

    state_t                state_q, state_d;
    logic                  rd, wr, is_io, commit;
    logic [DEPTH_LOG2-1:0] idx;
    logic [15:0]           mem_q [DEPTH];
    logic [15:0]           sw_meta_q, sw_sync_q;
    logic [15:0]           rdata_q, rdata_d;
    logic [15:0]           hex_q, hex_d;
    logic                  conflict_q, conflict_d;

    // wr wins when OE and WE are both low
    assign rd    = ~Mem_CE & ~Mem_OE & Mem_WE;
    assign wr    = ~Mem_CE & ~Mem_WE;
    assign is_io = (ADDR == IO_ADDR);
    assign idx   = ADDR[DEPTH_LOG2-1:0];

    always_comb begin
        state_d = IDLE;
        commit  = 1'b0;
        unique case (state_q)
            IDLE, RD: begin
                if (wr)      state_d = WR1;
                else if (rd) state_d = RD;
            end
            WR1: begin
                if (wr) begin
                    state_d = WR2;
                    commit  = 1'b1;
                end
            end
            WR2: begin
                if (wr)      state_d = WR2;
                else if (rd) state_d = RD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d    = rdata_q;
        hex_d      = hex_q;
        conflict_d = conflict_q | (~Mem_CE & ~Mem_OE & ~Mem_WE);
        if (rd)
            rdata_d = is_io ? sw_sync_q : mem_q[idx];
        if (commit && is_io) begin
            if (!Mem_UB) hex_d[15:8] = Data_to_SRAM[15:8];
            if (!Mem_LB) hex_d[7:0]  = Data_to_SRAM[7:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            rdata_q    <= '0;
            hex_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sw_meta_q  <= Switches;
            sw_sync_q  <= sw_meta_q;
            rdata_q    <= rdata_d;
            hex_q      <= hex_d;
            conflict_q <= conflict_d;
        end
    end

    // Array is not reset; commit is already low while Reset holds state in IDLE
    always_ff @(posedge Clk) begin
        if (commit && !is_io) begin
            if (!Mem_UB) mem_q[idx][15:8] <= Data_to_SRAM[15:8];
            if (!Mem_LB) mem_q[idx][7:0]  <= Data_to_SRAM[7:0];
        end
    end

    assign Data_from_SRAM = rdata_q;
    assign Hex_Out        = hex_q;
    assign Conflict       = conflict_q;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed vector bench for lc3_mem_responder.
module tb_lc3_mem_responder;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic [15:0] ADDR, Data_to_SRAM, Switches;
    logic [15:0] Data_from_SRAM, Hex_Out;
    logic        Conflict;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        ce, oe, we, ub, lb;
        logic [15:0] a, d;
        bit          chk;
        logic [15:0] ed, eh;
        logic        ec;
    } vec_t;

    vec_t vq[$];

    lc3_mem_responder #(.DEPTH_LOG2(10), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Switches(Switches),
        .Data_from_SRAM(Data_from_SRAM), .Hex_Out(Hex_Out),
        .Conflict(Conflict)
    );

    always #5 Clk = ~Clk;

    task automatic cmp(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check3(input string nm, input logic [15:0] ed,
                          input logic [15:0] eh, input logic ec);
        cmp({nm, ".dout"}, Data_from_SRAM, ed);
        cmp({nm, ".hex"}, Hex_Out, eh);
        cmp({nm, ".conf"}, {15'd0, Conflict}, {15'd0, ec});
    endtask

    task automatic row(input logic ce, oe, we, ub, lb,
                       input logic [15:0] a, d, input bit chk,
                       input logic [15:0] ed, eh, input logic ec);
        vec_t v;
        v.ce = ce; v.oe = oe; v.we = we; v.ub = ub; v.lb = lb;
        v.a = a; v.d = d; v.chk = chk; v.ed = ed; v.eh = eh; v.ec = ec;
        vq.push_back(v);
    endtask

    task automatic idle(input bit chk, input logic [15:0] ed, eh,
                        input logic ec);
        row(1, 1, 1, 1, 1, 16'h0, 16'h0, chk, ed, eh, ec);
    endtask

    task automatic wr(input logic [15:0] a, d, input logic ub, lb);
        row(0, 1, 0, ub, lb, a, d, 0, 0, 0, 0);
        row(0, 1, 0, ub, lb, a, d, 0, 0, 0, 0);
        idle(0, 0, 0, 0);
    endtask

    task automatic rdc(input logic [15:0] a, ed, eh, input logic ec);
        row(0, 0, 1, 1, 1, a, 16'h0, 1, ed, eh, ec);
    endtask

    task automatic drive(input vec_t v);
        Mem_CE = v.ce; Mem_OE = v.oe; Mem_WE = v.we;
        Mem_UB = v.ub; Mem_LB = v.lb;
        ADDR = v.a; Data_to_SRAM = v.d;
    endtask

    task automatic set_idle();
        Mem_CE = 1; Mem_OE = 1; Mem_WE = 1; Mem_UB = 1; Mem_LB = 1;
        ADDR = 0; Data_to_SRAM = 0;
    endtask

    initial begin
        Reset = 1'b1;
        Switches = 16'h5A5A;
        set_idle();

        idle(1, 16'h0000, 16'h0000, 0);
        wr(16'h0010, 16'hBEEF, 0, 0);
        idle(1, 16'h0000, 16'h0000, 0);
        rdc(16'h0010, 16'hBEEF, 16'h0000, 0);
        rdc(16'h0010, 16'hBEEF, 16'h0000, 0);
        wr(16'h0020, 16'h1234, 0, 0);
        wr(16'h0020, 16'hABCD, 1, 0);
        rdc(16'h0020, 16'h12CD, 16'h0000, 0);
        wr(16'h0020, 16'hABCD, 0, 1);
        rdc(16'h0020, 16'hABCD, 16'h0000, 0);
        wr(16'h0020, 16'h0000, 1, 1);
        rdc(16'h0020, 16'hABCD, 16'h0000, 0);
        rdc(16'hFFFF, 16'h5A5A, 16'h0000, 0);
        wr(16'h03FF, 16'h1111, 0, 0);
        wr(16'hFFFF, 16'h00FF, 0, 0);
        idle(1, 16'h5A5A, 16'h00FF, 0);
        rdc(16'h03FF, 16'h1111, 16'h00FF, 0);
        wr(16'h0030, 16'h0001, 0, 0);
        row(0, 1, 0, 0, 0, 16'h0030, 16'h7777, 0, 0, 0, 0);
        idle(0, 0, 0, 0);
        rdc(16'h0030, 16'h0001, 16'h00FF, 0);
        row(0, 1, 0, 0, 0, 16'h0030, 16'h1111, 0, 0, 0, 0);
        row(0, 1, 0, 0, 0, 16'h0030, 16'h2222, 0, 0, 0, 0);
        row(0, 1, 0, 0, 0, 16'h0030, 16'h3333, 0, 0, 0, 0);
        row(0, 1, 0, 0, 0, 16'h0030, 16'h4444, 0, 0, 0, 0);
        idle(0, 0, 0, 0);
        rdc(16'h0030, 16'h2222, 16'h00FF, 0);
        row(0, 0, 0, 0, 0, 16'h0040, 16'h4444, 1, 16'h2222, 16'h00FF, 1);
        row(0, 0, 0, 0, 0, 16'h0040, 16'h4444, 1, 16'h2222, 16'h00FF, 1);
        idle(1, 16'h2222, 16'h00FF, 1);
        rdc(16'h0040, 16'h4444, 16'h00FF, 1);
        wr(16'h0400, 16'hCAFE, 0, 0);
        rdc(16'h0000, 16'hCAFE, 16'h00FF, 1);
        wr(16'h0050, 16'h5555, 0, 0);
        rdc(16'h0050, 16'h5555, 16'h00FF, 1);

        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        foreach (vq[i]) begin
            @(negedge Clk);
            drive(vq[i]);
            @(posedge Clk);
            #1;
            if (vq[i].chk) check3($sformatf("vec%0d", i), vq[i].ed,
                                  vq[i].eh, vq[i].ec);
        end

        // switch change: visible on the 3rd read edge
        @(negedge Clk);
        Switches = 16'hC3C3;
        for (int k = 0; k < 3; k++) begin
            Mem_CE = 0; Mem_OE = 0; Mem_WE = 1; ADDR = 16'hFFFF;
            @(posedge Clk);
            #1;
            cmp($sformatf("swlat%0d", k), Data_from_SRAM,
                (k == 2) ? 16'hC3C3 : 16'h5A5A);
            @(negedge Clk);
        end

        // reset during WR1 of a write to 0x0050: no commit
        Mem_CE = 0; Mem_OE = 1; Mem_WE = 0; Mem_UB = 0; Mem_LB = 0;
        ADDR = 16'h0050; Data_to_SRAM = 16'h9999;
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1 check3("rst_async", 16'h0000, 16'h0000, 0);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        set_idle();
        @(posedge Clk);
        #1 check3("rst_after", 16'h0000, 16'h0000, 0);
        @(negedge Clk);
        Mem_CE = 0; Mem_OE = 0; Mem_WE = 1; ADDR = 16'h0050;
        @(posedge Clk);
        #1 check3("rst_nocommit", 16'h5555, 16'h0000, 0);
        @(negedge Clk);
        ADDR = 16'h0000;
        @(posedge Clk);
        #1 check3("rst_retain", 16'hCAFE, 16'h0000, 0);
        @(negedge Clk);
        set_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lc3_mem_responder.md
# lc3_mem_responder

Memory-side responder for the LC-3 datapath: answers the active-low SRAM strobes (Mem_CE/UB/LB/OE/WE) that the control unit drives, serving reads and writes from an on-chip word array. One I/O address maps to the board switches for reads and the hex display for writes. It sits between MAR/MDR and the top level, and the two-cycle read/write strobe bursts issued by the control unit must complete against it with no wait states.

## Interface
- DEPTH_LOG2, 10: array holds 2**DEPTH_LOG2 16-bit words.
- IO_ADDR, 16'hFFFF: address of the switch/hex I/O register.
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Mem_CE  in  1  chip enable, active-low.
- Mem_UB  in  1  upper-byte enable, active-low (writes only).
- Mem_LB  in  1  lower-byte enable, active-low (writes only).
- Mem_OE  in  1  output enable / read strobe, active-low.
- Mem_WE  in  1  write strobe, active-low.
- ADDR  in  16  word address (from MAR).
- Data_to_SRAM  in  16  write data (from MDR).
- Switches  in  16  asynchronous board switches.
- Data_from_SRAM  out  16  read data (to MDR).
- Hex_Out  out  16  hex display register.
- Conflict  out  1  sticky: OE and WE sampled low together.

## Operation
- Access qualifiers, sampled at each rising Clk: rd = ~Mem_CE & ~Mem_OE & Mem_WE; wr = ~Mem_CE & ~Mem_WE.
- Array index = ADDR[DEPTH_LOG2-1:0]; upper address bits ignored (aliasing) except exact match ADDR == IO_ADDR, which selects I/O instead of the array.
- Switches pass through a 2-flop synchronizer (reset 0) before use.
- FSM states: IDLE, RD, WR1, WR2.
  - IDLE: rd -> RD; wr -> WR1; else IDLE.
  - RD: rd -> RD; wr -> WR1; else IDLE.
  - WR1: wr -> WR2 and commit write; else IDLE (no commit).
  - WR2: wr -> WR2 (no further commit); rd -> RD; else IDLE.
  - Mem_CE high in any state -> IDLE next edge; a write in WR1 is aborted.
- Read: on every edge with rd, Data_from_SRAM <= array[index], or synchronized Switches if IO_ADDR. Otherwise Data_from_SRAM holds its value. Reads always return a full word; UB/LB are ignored.
- Write commit happens on the second consecutive wr edge only (WR1 -> WR2), using ADDR/Data_to_SRAM sampled at that edge. Exactly one commit per WE-low burst of at least 2 cycles. A 1-cycle WE pulse writes nothing.
- Byte lanes on commit: ~Mem_UB writes [15:8]; ~Mem_LB writes [7:0]. Both high means the commit is a no-op, but the FSM still advances. The same rules apply to Hex_Out when ADDR == IO_ADDR (array untouched).
- OE and WE both low with CE low: treated as a write (wr wins), no read update. Conflict <= 1, held until Reset.
- Array contents are not reset (undefined until written).

## Timing
- Reset values: Data_from_SRAM = 0, Hex_Out = 0, Conflict = 0, state IDLE, sync flops 0.
- Read latency is 1 edge. OE low during cycle n gives Data_from_SRAM valid throughout cycle n+1, ready for the MDR load at the end of the control unit's second OE cycle.
- Write latency is 2 edges. Array/Hex_Out are updated at the second rising edge of the WE-low burst, and a read in the following cycle returns the new data.
- Switch change reaches Data_from_SRAM on the 3rd edge with rd after the change (2 sync + 1 read).
- Reset asserted mid-write (WR1) means no commit. Asserted after WR2, the committed data is retained.

## Test plan
- Write 16'hBEEF to addr 16'h0010 (WE low 2 cycles, UB=LB=0), then OE low 2 cycles at 16'h0010 -> Data_from_SRAM = 16'hBEEF in the 2nd OE cycle. Conflict = 0.
- Preload 16'h1234 at 16'h0020, write 16'hABCD with UB=1, LB=0 -> readback 16'h12CD. Then with UB=0, LB=1 -> 16'hAB CD (16'hABCD).
- Switches = 16'h5A5A, wait 2 cycles, read IO_ADDR -> 16'h5A5A. Write 16'h00FF to IO_ADDR -> Hex_Out = 16'h00FF, and array[IO_ADDR low bits] is unchanged.
- 1-cycle WE pulse of 16'h7777 to 16'h0030 (previous 16'h0001) -> readback 16'h0001. WE low 4 cycles with data changing after cycle 2 -> only the cycle-2 data is stored.
- OE and WE low together on 16'h0040 with data 16'h4444 -> 16'h4444 stored, Data_from_SRAM unchanged that edge, Conflict = 1 and stays 1 until Reset.
- Write 16'hCAFE to 16'h0400 with DEPTH_LOG2 = 10 -> reading 16'h0000 returns 16'hCAFE. Assert Reset during WR1 of a write to 16'h0050 -> no commit, all outputs 0.
